// File: rtl/otter_bus_arbiter.sv
// Two-master round-robin arbiter sharing the OTTER SRAM port, with a watchdog on slave completion.
// Latency: grant (s_req) one cycle after a request is seen in IDLE; master ack is combinational with s_ack; one dead cycle follows.
// Backpressure: masters hold req until their ack; the slave stalls by withholding s_ack, cut off after TIMEOUT cycles.
module otter_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic                  m0_we,
  input  logic [DATA_W/8-1:0]   m0_be,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic                  m1_we,
  input  logic [DATA_W/8-1:0]   m1_be,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  s_req,
  output logic [ADDR_W-1:0]     s_addr,
  output logic                  s_we,
  output logic [DATA_W/8-1:0]   s_be,
  output logic [DATA_W-1:0]     s_wdata,
  input  logic                  s_ack,
  input  logic [DATA_W-1:0]     s_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_grant, last_grant_nxt;
  logic [7:0] cnt;
  logic       done;
  logic       err;
  bus_req_t   req0, req1, req_own;

  // Request fields of the current owner go straight to the slave.
  assign req0    = {m0_addr, m0_we, m0_be, m0_wdata};
  assign req1    = {m1_addr, m1_we, m1_be, m1_wdata};
  assign req_own = owner ? req1 : req0;
  assign s_addr  = req_own.addr;
  assign s_we    = req_own.we;
  assign s_be    = req_own.be;
  assign s_wdata = req_own.wdata;

  // Completion pulses and error flags are steered only to the owner.
  assign m0_ack = done & ~owner;
  assign m1_ack = done &  owner;
  assign m0_err = err  & ~owner;
  assign m1_err = err  &  owner;

  // State, owner and fairness registers; last_grant resets to 1 so master 0 wins first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Watchdog: zero outside BUSY, counts BUSY cycles without s_ack, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (state != BUSY) begin
      cnt <= 8'd0;
    end else if (!s_ack && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Arbitration, slave handshake and completion; s_ack wins over a timeout in the same cycle.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    s_req          = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    m_rdata        = '0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_nxt = (m0_req && m1_req) ? ~last_grant : m1_req;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_req = 1'b1;
        if (s_ack) begin
          done    = 1'b1;
          m_rdata = s_rdata;
        end else if (cnt >= TO_LIM) begin
          done = 1'b1;
          err  = 1'b1;
        end
        if (done) begin
          last_grant_nxt = owner;
          state_nxt      = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_otter_bus_arbiter.sv
// Bench for otter_bus_arbiter: transaction-level model checked every cycle plus directed scenarios.
// Latency: model tracks BUSY cycle index per grant; acks expected in the s_ack cycle or BUSY cycle TO+1.
// Backpressure: bench masters hold req until ack; bench slave acks after a programmable number of BUSY cycles.
module tb_otter_bus_arbiter;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          who;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } ack_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq [2];
  logic [31:0] maddr [2];
  logic        mwe [2];
  logic [3:0]  mbe [2];
  logic [31:0] mwdata [2];
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m_rdata;
  logic        s_req, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;

  txn_t q0[$];
  txn_t q1[$];
  ack_t alog[$];
  gnt_t glog[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int req_rise1 = 0;
  int slave_lat = 0;
  logic [31:0] slave_rdata = 32'hDEADBEEF;
  logic spurious = 1'b0;

  // model state: mk = index of current BUSY cycle (0 = not busy)
  int mk = 0;
  bit mdead = 1'b0;
  int mown = 0;
  int mlast = 1;

  otter_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_we(mwe[0]), .m0_be(mbe[0]), .m0_wdata(mwdata[0]),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_we(mwe[1]), .m1_be(mbe[1]), .m1_wdata(mwdata[1]),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Cycle-level expectation from the transaction rules, evaluated mid-cycle.
  task automatic model_step();
    bit          done;
    bit          e_err;
    logic [31:0] e_rdata;
    if (!rst) begin
      chk("rst_s_req", {31'd0, s_req}, 32'd0);
      chk("rst_acks", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
      chk("rst_m_rdata", m_rdata, 32'd0);
      mk = 0; mdead = 1'b0; mlast = 1; mown = 0;
      return;
    end
    done    = (mk > 0) && (s_ack || mk == TO + 1);
    e_err   = done && !s_ack;
    e_rdata = (done && s_ack) ? s_rdata : 32'd0;
    chk("s_req", {31'd0, s_req}, {31'd0, mk > 0});
    chk("m0_ack", {31'd0, m0_ack}, {31'd0, done && mown == 0});
    chk("m1_ack", {31'd0, m1_ack}, {31'd0, done && mown == 1});
    chk("m0_err", {31'd0, m0_err}, {31'd0, e_err && mown == 0});
    chk("m1_err", {31'd0, m1_err}, {31'd0, e_err && mown == 1});
    chk("m_rdata", m_rdata, e_rdata);
    if (mk > 0) begin
      assert (mreq[mown]) else $error("protocol: owner dropped its request while busy");
      chk("s_addr", s_addr, maddr[mown]);
      chk("s_we", {31'd0, s_we}, {31'd0, mwe[mown]});
      chk("s_be", {28'd0, s_be}, {28'd0, mbe[mown]});
      chk("s_wdata", s_wdata, mwdata[mown]);
    end
    if (mk > 0) begin
      if (done) begin mlast = mown; mk = 0; mdead = 1'b1; end
      else mk++;
    end else if (mdead) begin
      mdead = 1'b0;
    end else if (mreq[0] || mreq[1]) begin
      mown = (mreq[0] && mreq[1]) ? 1 - mlast : (mreq[1] ? 1 : 0);
      mk = 1;
    end
  endtask

  always @(negedge clk) model_step();

  // Event logs of what the DUT actually did, for the directed checks.
  logic prev_sreq = 1'b0;
  always @(negedge clk) begin
    if (m0_ack || m1_ack)
      alog.push_back('{m1_ack ? 1 : 0, m0_err | m1_err, m_rdata, cyc});
    if (s_req && !prev_sreq)
      glog.push_back('{cyc, s_addr, s_we, s_wdata});
    prev_sreq = s_req;
  end

  // Bench master: raise req with the next queued transaction, hold until ack.
  task automatic master_run(input int mi);
    txn_t t;
    logic got;
    int   have;
    forever begin
      @(negedge clk);
      got = (mi == 0) ? m0_ack : m1_ack;
      @(posedge clk);
      #1;
      have = (mi == 0) ? q0.size() : q1.size();
      if ((mreq[mi] && got) || (!mreq[mi] && have > 0)) begin
        if (have > 0) begin
          t = (mi == 0) ? q0.pop_front() : q1.pop_front();
          if (mi == 1 && !mreq[1]) req_rise1 = cyc;
          maddr[mi] = t.addr; mwe[mi] = t.we; mbe[mi] = t.be; mwdata[mi] = t.wdata;
          mreq[mi] = 1'b1;
        end else begin
          mreq[mi] = 1'b0;
        end
      end
    end
  endtask

  initial master_run(0);
  initial master_run(1);

  // Bench slave: ack in BUSY cycle slave_lat+1 (never if negative), plus optional spurious ack.
  initial begin
    int k;
    k = 0;
    s_ack = 1'b0;
    s_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (s_req) k++; else k = 0;
      s_ack = spurious || (slave_lat >= 0 && s_req && k == slave_lat + 1);
      s_rdata = s_ack ? slave_rdata : 32'hBAD0BAD0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic wait_acks(input string nm, input int n, input int budget);
    int i;
    i = 0;
    while (alog.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk(nm, alog.size(), n);
  endtask

  task automatic wait_glog(input string nm, input int n, input int budget);
    int i;
    i = 0;
    while (glog.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk(nm, glog.size(), n);
  endtask

  task automatic chk_ack(input string nm, input int idx, input int who, input logic err,
                         input logic [31:0] rd);
    if (idx < alog.size()) begin
      chk({nm, "_who"}, alog[idx].who, who);
      chk({nm, "_err"}, {31'd0, alog[idx].err}, {31'd0, err});
      chk({nm, "_rdata"}, alog[idx].rdata, rd);
    end else begin
      chk({nm, "_missing"}, alog.size(), idx + 1);
    end
  endtask

  initial begin
    int ab, gb, n_m1, m1_idx, d;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mreq[i] = 1'b0; maddr[i] = '0; mwe[i] = 1'b0; mbe[i] = '0; mwdata[i] = '0;
    end
    step(3);
    rst = 1'b1;

    // single m0 read of 0x100
    slave_lat = 0; slave_rdata = 32'hDEADBEEF;
    q0.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
    wait_acks("t1_wait", 1, 20);
    chk_ack("t1", 0, 0, 1'b0, 32'hDEADBEEF);
    if (glog.size() > 0) begin
      chk("t1_s_addr", glog[0].addr, 32'h100);
      chk("t1_ack_same_cycle", alog[0].cyc - glog[0].cyc, 0);
    end
    n_m1 = 0;
    foreach (alog[i]) if (alog[i].who == 1) n_m1++;
    chk("t1_no_m1_ack", n_m1, 0);
    step(4);

    // reset, then simultaneous requests: alternation m0,m1,m0,m1,m0,m1
    rst = 1'b0; step(2); rst = 1'b1;
    ab = alog.size(); gb = glog.size();
    slave_rdata = 32'h0000_2020;
    q0.push_back('{32'h10, 1'b1, 4'hF, 32'h11223344});
    q0.push_back('{32'h14, 1'b0, 4'hF, 32'h0});
    q0.push_back('{32'h18, 1'b0, 4'h3, 32'h0});
    q1.push_back('{32'h20, 1'b0, 4'hF, 32'h0});
    q1.push_back('{32'h24, 1'b1, 4'hC, 32'hCAFE0000});
    q1.push_back('{32'h28, 1'b0, 4'hF, 32'h0});
    wait_acks("t2_wait", ab + 6, 60);
    for (int i = 0; i < 6; i++) chk_ack("t2_order", ab + i, i % 2, 1'b0, 32'h0000_2020);
    if (glog.size() >= gb + 2) begin
      chk("t2_first_addr", glog[gb].addr, 32'h10);
      chk("t2_first_we", {31'd0, glog[gb].we}, 32'd1);
      chk("t2_first_wdata", glog[gb].wdata, 32'h11223344);
      chk("t2_second_addr", glog[gb + 1].addr, 32'h20);
      chk("t2_spacing", glog[gb + 1].cyc - glog[gb].cyc, 3);
    end
    step(4);

    // continuous m0 every 3 cycles, then m1 joins and is granted at the next IDLE
    ab = alog.size(); gb = glog.size();
    slave_rdata = 32'h3333_0000;
    for (int i = 0; i < 4; i++) q0.push_back('{32'h200 + 32'(4 * i), 1'b0, 4'hF, 32'h0});
    wait_acks("t3_wait_m0", ab + 3, 40);
    if (glog.size() >= gb + 3) begin
      chk("t3_gap1", glog[gb + 1].cyc - glog[gb].cyc, 3);
      chk("t3_gap2", glog[gb + 2].cyc - glog[gb + 1].cyc, 3);
    end
    q1.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
    wait_acks("t3_wait_all", ab + 5, 40);
    m1_idx = -1;
    for (int i = gb; i < glog.size(); i++) if (glog[i].addr == 32'h300) m1_idx = i;
    d = (m1_idx >= 0) ? glog[m1_idx].cyc - req_rise1 : -1;
    chk("t3_m1_wait_le3", {31'd0, d >= 1 && d <= 3}, 32'd1);
    n_m1 = 0;
    for (int i = ab; i < alog.size(); i++) if (alog[i].who == 1) n_m1++;
    chk("t3_m1_once", n_m1, 1);
    step(4);

    // slave never acks: error ack in BUSY cycle TO+1, then pending m1 served (also times out)
    ab = alog.size(); gb = glog.size();
    slave_lat = -1;
    q0.push_back('{32'h400, 1'b0, 4'hF, 32'h0});
    wait_glog("t4_grant", gb + 1, 10);
    q1.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
    wait_acks("t4_wait", ab + 2, 40);
    chk_ack("t4_m0_timeout", ab, 0, 1'b1, 32'h0);
    chk_ack("t4_m1_timeout", ab + 1, 1, 1'b1, 32'h0);
    if (alog.size() >= ab + 2 && glog.size() >= gb + 2) begin
      chk("t4_err_busy_cycle5", alog[ab].cyc - glog[gb].cyc, 4);
      chk("t4_m1_grant_gap", glog[gb + 1].cyc - alog[ab].cyc, 3);
      chk("t4_m1_addr", glog[gb + 1].addr, 32'h500);
    end
    step(4);

    // s_ack exactly in BUSY cycle TO+1 beats the timeout
    ab = alog.size(); gb = glog.size();
    slave_lat = TO; slave_rdata = 32'h5A5A5A5A;
    q0.push_back('{32'h600, 1'b0, 4'hF, 32'h0});
    wait_acks("t5_wait", ab + 1, 20);
    chk_ack("t5_ack_wins", ab, 0, 1'b0, 32'h5A5A5A5A);
    if (alog.size() > ab && glog.size() > gb)
      chk("t5_ack_cycle", alog[ab].cyc - glog[gb].cyc, 4);
    step(4);

    // reset in the second BUSY cycle, then contention grants m0 first
    ab = alog.size(); gb = glog.size();
    slave_lat = -1;
    q0.push_back('{32'h700, 1'b0, 4'hF, 32'h0});
    wait_glog("t6_grant", gb + 1, 10);
    step(1);
    q1.push_back('{32'h704, 1'b0, 4'hF, 32'h0});
    rst = 1'b0;
    #1;
    chk("t6_s_req_drop", {31'd0, s_req}, 32'd0);
    chk("t6_no_ack_now", {30'd0, m0_ack, m1_ack}, 32'd0);
    step(3);
    chk("t6_no_ack_in_reset", alog.size(), ab);
    slave_lat = 0; slave_rdata = 32'h7777_0000;
    rst = 1'b1;
    wait_acks("t6_wait", ab + 2, 20);
    chk_ack("t6_first_m0", ab, 0, 1'b0, 32'h7777_0000);
    chk_ack("t6_then_m1", ab + 1, 1, 1'b0, 32'h7777_0000);
    step(4);

    // spurious s_ack while idle: nothing happens, next request behaves normally
    ab = alog.size(); gb = glog.size();
    spurious = 1'b1; step(1); spurious = 1'b0; step(3);
    chk("t7_no_ack", alog.size(), ab);
    chk("t7_no_grant", glog.size(), gb);
    slave_rdata = 32'h8888_8888;
    q1.push_back('{32'h800, 1'b0, 4'hF, 32'h0});
    wait_acks("t7_wait", ab + 1, 20);
    chk_ack("t7_normal", ab, 1, 1'b0, 32'h8888_8888);
    step(4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/otter_bus_arbiter.md
# otter_bus_arbiter

Two-master, one-slave arbiter that shares the OTTER system memory (SRAM) between the CPU core (master 0) and an auxiliary requester (master 1, e.g. DMA or debug loader). It sits between the masters and the SRAM in the top-level wrapper. It serialises single-beat transactions with round-robin fairness and a watchdog timeout that terminates hung slave accesses with an error.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- TIMEOUT, 255, max cycles to wait for s_ack before an error termination; must be ≥1; the timeout counter is 8 bits wide
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- mX_req  in  1  master X (X=0,1) request; held high with fields stable until mX_ack
- mX_addr  in  ADDR_W  byte address
- mX_we  in  1  1 = write, 0 = read
- mX_be  in  DATA_W/8  byte enables
- mX_wdata  in  DATA_W  write data
- mX_ack  out  1  one-cycle completion pulse for master X
- mX_err  out  1  valid with mX_ack; 1 = transaction timed out
- m_rdata  out  DATA_W  read data, shared by both masters, valid in the mX_ack cycle of a read
- s_req  out  1  slave request
- s_addr, s_we, s_be, s_wdata  out  as above  slave request fields, muxed from the owning master
- s_ack  in  1  slave completion pulse; s_rdata valid in the same cycle
- s_rdata  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - Single request: grant that master.
  - Both requesting: grant the master that does not match the last_grant register.
  - On a grant, the owner register is loaded and the state moves to BUSY.
- BUSY:
  - s_req = 1; s_addr/s_we/s_be/s_wdata are driven combinationally from the owner's inputs.
  - On s_ack: owner_ack = 1, err = 0, m_rdata = s_rdata (pass-through). last_grant is set to the owner and the state moves to DONE.
  - If the timeout counter reaches TIMEOUT without s_ack: owner_ack = 1, err = 1, m_rdata = 0. s_req is dropped and the state moves to DONE. last_grant is updated as for a normal completion.
- DONE: one dead cycle with s_req = 0, so that a master can deassert its request before the next arbitration. Always moves to IDLE.
- A master's request must stay high until its ack. A request dropped while BUSY is a protocol violation; behaviour is undefined and the bench asserts against it.
- A non-owner master sees mX_ack = 0 and mX_err = 0 at all times.
- s_ack outside BUSY is ignored and must not generate any mX_ack.
- Timeout counter:
  - Cleared when entering BUSY.
  - Increments each BUSY cycle without s_ack.
  - Saturates; it never wraps.

## Timing
- Reset values (asynchronous, while rst = 0): state = IDLE, last_grant = 1 (so master 0 wins the first contention), owner = 0, counter = 0.
- Outputs during reset: s_req = 0, all mX_ack = 0, all mX_err = 0, m_rdata = 0.
- Reset mid-transaction: s_req drops immediately and no ack is issued. The slave is responsible for discarding any in-flight access.
- Cycle N: request sampled high in IDLE. Cycle N+1: BUSY, s_req = 1. Ack to the master occurs in the same cycle as s_ack.
- With a zero-wait slave (s_ack in the first BUSY cycle), each transaction occupies 3 cycles (IDLE, BUSY, DONE). Back-to-back throughput is one transaction every 3 cycles.
- Timeout: the error ack is asserted in BUSY cycle number TIMEOUT+1, counting the first BUSY cycle as 1. If s_ack arrives in that same cycle, s_ack wins and err = 0.
- A request that arrives while another transaction is BUSY waits at most one full transaction (bounded by TIMEOUT+3 cycles) before it is granted.

## Test plan
- Reset then a single m0 read of addr 0x100: s_req rises the cycle after m0_req is sampled, with s_addr = 0x100. Slave acks with s_rdata = 0xDEADBEEF → m0_ack pulses one cycle, m_rdata = 0xDEADBEEF, m0_err = 0, m1_ack stays 0.
- Both masters request at the same time immediately after reset, with m0 writing 0x11223344 to 0x10 and m1 reading 0x20 → m0 is served first, then m1. Continuous requests thereafter alternate m0, m1, m0, m1.
- Continuous m0 requests with no m1 activity → m0 is granted every 3 cycles. When m1_req rises, it is granted at the next IDLE.
- Slave never acks, TIMEOUT = 4 → in BUSY cycle 5 the owner sees ack = 1 and err = 1, with m_rdata = 0. s_req drops, and a pending m1 request is granted afterwards.
- rst pulled low in the second BUSY cycle → s_req goes to 0 immediately and no ack is issued. After release, a contention grants m0 first.
- Spurious s_ack in IDLE → no mX_ack, and the state does not change.
